// File: rtl/seq_mult16_pkg.sv
// Shared constants, state encoding and carry-lookahead helpers for seq_mult16.
// Optional build macro used elsewhere in this slice: MULT_SIGNED_EN.
package seq_mult16_pkg;

    localparam int MULT_W = 16;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Carries c1..c4 of a 4-bit lookahead block with carry-in c0.
    function automatic logic [3:0] cla_carry4(input logic [3:0] g, input logic [3:0] p, input logic c0);
        logic [3:0] c;
        c[0] = g[0] | (p[0] & c0);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    function automatic logic [2:0] cla_carry3(input logic [2:0] g, input logic [2:0] p, input logic c0);
        logic [2:0] c;
        c[0] = g[0] | (p[0] & c0);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

endpackage

// File: rtl/seq_mult16_if.sv
// Operand/result bundle between the operand path (master) and seq_mult16 (slave).
interface seq_mult16_if;
    import seq_mult16_pkg::*;

    logic                  start;
    logic [MULT_W-1:0]     a;
    logic [MULT_W-1:0]     b;
    logic                  busy;
    logic                  done;
    logic [2*MULT_W-1:0]   product;

    modport master (output start, output a, output b, input busy, input done, input product);
    modport slave  (input start, input a, input b, output busy, output done, output product);

endinterface

// File: rtl/seq_mult16_cla.sv
// 16-bit two-level carry-lookahead adder: four 4-bit blocks plus a group lookahead unit.
module seq_mult16_cla
    import seq_mult16_pkg::*;
(
    input  logic [MULT_W-1:0] a_i,
    input  logic [MULT_W-1:0] b_i,
    input  logic              cin_i,
    output logic [MULT_W-1:0] sum_o,
    output logic              cout_o
);

    logic [15:0] g_s;
    logic [15:0] p_s;
    logic [3:0]  gg_s;
    logic [3:0]  gp_s;
    logic [4:0]  gc_s;
    logic [15:0] cbit_s;

    // Bit, group and block carries, then the sum.
    always_comb begin
        g_s    = a_i & b_i;
        p_s    = a_i ^ b_i;
        gg_s   = 4'h0;
        gp_s   = 4'h0;
        cbit_s = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            gg_s[i] = grp_gen(g_s[4*i +: 4], p_s[4*i +: 4]);
            gp_s[i] = &p_s[4*i +: 4];
        end
        gc_s[0]   = cin_i;
        gc_s[4:1] = cla_carry4(gg_s, gp_s, cin_i);
        for (int i = 0; i < 4; i++) begin
            cbit_s[4*i]       = gc_s[i];
            cbit_s[4*i+1 +: 3] = cla_carry3(g_s[4*i +: 3], p_s[4*i +: 3], gc_s[i]);
        end
        sum_o  = p_s ^ cbit_s;
        cout_o = gc_s[4];
    end

endmodule

// File: rtl/seq_mult16.sv
// Sequential 16x16 shift-and-add multiplier built around one CLA adder.
// Define MULT_SIGNED_EN for radix-2 Booth two's-complement operation.
module seq_mult16
    import seq_mult16_pkg::*;
#(
    parameter int N = MULT_W
)(
    input  logic         clk,
    input  logic         rst,
    seq_mult16_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    state_e              state_q;
    logic [MULT_W-1:0]   m_q;
    logic [MULT_W-1:0]   a_q;
    logic [MULT_W-1:0]   q_q;
    logic [MULT_W-1:0]   a_d;
    logic [MULT_W-1:0]   q_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;
    logic                done_q;
    logic [2*MULT_W-1:0] product_q;

    logic [MULT_W-1:0]   add_b_s;
    logic                add_cin_s;
    logic [MULT_W-1:0]   sum_s;
    logic                cout_s;

`ifdef MULT_SIGNED_EN
    logic                qm1_q;
    logic                qm1_d;
    logic                ovf_s;

    // Booth select and arithmetic shift; sign restored from the overflow flag.
    always_comb begin
        add_b_s   = 16'h0000;
        add_cin_s = 1'b0;
        case ({q_q[0], qm1_q})
            2'b01:   begin add_b_s = m_q;  add_cin_s = 1'b0; end
            2'b10:   begin add_b_s = ~m_q; add_cin_s = 1'b1; end
            default: begin add_b_s = 16'h0000; add_cin_s = 1'b0; end
        endcase
        ovf_s = (a_q[15] == add_b_s[15]) & (sum_s[15] != a_q[15]);
        a_d   = {sum_s[15] ^ ovf_s, sum_s[15:1]};
        q_d   = {sum_s[0], q_q[15:1]};
        qm1_d = q_q[0];
    end
`else
    // Unsigned step: the adder carry lands in A[15]; the bit shifted into C is always zero.
    always_comb begin
        if (q_q[0]) begin
            add_b_s = m_q;
        end else begin
            add_b_s = 16'h0000;
        end
        add_cin_s = 1'b0;
        a_d       = {cout_s, sum_s[15:1]};
        q_d       = {sum_s[0], q_q[15:1]};
    end
`endif

    seq_mult16_cla u_cla (
        .a_i    (a_q),
        .b_i    (add_b_s),
        .cin_i  (add_cin_s),
        .sum_o  (sum_s),
        .cout_o (cout_s)
    );

    // Control FSM with its datapath registers and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            m_q       <= 16'h0000;
            a_q       <= 16'h0000;
            q_q       <= 16'h0000;
            cnt_q     <= 4'h0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= 32'h0000_0000;
`ifdef MULT_SIGNED_EN
            qm1_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        m_q     <= bus.a;
                        q_q     <= bus.b;
                        a_q     <= 16'h0000;
                        cnt_q   <= 4'h0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
`ifdef MULT_SIGNED_EN
                        qm1_q   <= 1'b0;
`endif
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 4'd1;
`ifdef MULT_SIGNED_EN
                    qm1_q <= qm1_d;
`endif
                    if (cnt_q == LAST_CNT) begin
                        product_q <= {a_d, q_d};
                        state_q   <= ST_DONE;
                    end else begin
                        state_q   <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule

// File: tb/tb_seq_mult16.sv
// Directed self-checking bench for seq_mult16 (unsigned, or Booth with MULT_SIGNED_EN).
module tb_seq_mult16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    seq_mult16_if bus ();

    seq_mult16 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One operation; optionally pulses start mid-run, which must be ignored.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic [31:0] exp, input bit inject);
        int cyc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 16'hDEAD;
        bus.b     = 16'hBEEF;
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 40) begin
            bus.start = inject && (cyc == 5);
            @(negedge clk);
            cyc++;
            if (inject && cyc == 6) check({tag, "_busy_ign"}, {31'd0, bus.busy}, 32'd1);
        end
        bus.start = 1'b0;
        check({tag, "_lat"}, cyc, 32'd18);
        check({tag, "_prod"}, bus.product, exp);
        @(negedge clk);
        check({tag, "_done_1cyc"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_hold"}, bus.product, exp);
    endtask

    initial begin
        int cyc;
        int n_done;
        int t_done [3];

        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 16'h0000;
        bus.b     = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_prod", bus.product, 32'd0);
        rst = 1'b0;

        run_op("u3x5", 16'd3, 16'd5, 32'h0000_000F, 1'b0);
`ifdef MULT_SIGNED_EN
        run_op("ffxff", 16'hFFFF, 16'hFFFF, 32'h0000_0001, 1'b0);
`else
        run_op("ffxff", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0);
`endif

        // Reset in the middle of an operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'hABCD;
        bus.b     = 16'h1111;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        check("midrst_prod", bus.product, 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        n_done = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) n_done++;
        end
        check("midrst_nodone", n_done, 32'd0);
        check("midrst_idle", {31'd0, bus.busy}, 32'd0);

        run_op("z_ign", 16'h1234, 16'h0000, 32'h0000_0000, 1'b1);
        run_op("u2x7", 16'd2, 16'd7, 32'h0000_000E, 1'b0);

        // Start held high: back-to-back operations.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'd1;
        bus.b     = 16'd1;
        n_done    = 0;
        cyc       = 0;
        while (n_done < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.done === 1'b1) begin
                t_done[n_done] = cyc;
                n_done++;
                check("held_prod", bus.product, 32'd1);
                if (n_done == 3) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check("held_count", n_done, 32'd3);
        if (n_done == 3) begin
            check("held_first", t_done[0], 32'd18);
            check("held_gap1", t_done[1] - t_done[0], 32'd18);
            check("held_gap2", t_done[2] - t_done[1], 32'd18);
        end
        repeat (2) @(negedge clk);
        check("held_stop", {31'd0, bus.busy}, 32'd0);

`ifdef MULT_SIGNED_EN
        run_op("s_m3x5", 16'hFFFD, 16'd5, 32'hFFFF_FFF1, 1'b0);
        run_op("s_minxmin", 16'h8000, 16'h8000, 32'h4000_0000, 1'b0);
        run_op("s_maxxmin", 16'h7FFF, 16'h8000, 32'hC000_8000, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
